// File: rtl/mux_blk_pkg.sv
// mux_blk_pkg: shared sizing and types for the 10-way block mux, its select arbiter and the capture stage
//   NUM_BLK    - number of mux inputs (block_a .. block_j)
//   BLK_SEL_W  - width of the mux select
//   BLK_W      - data width of each block
//   blk_sel_t  - mux select type
//   arb_state_t- select arbiter FSM states
package mux_blk_pkg;
    localparam int NUM_BLK   = 10;
    localparam int BLK_SEL_W = 4;
    localparam int BLK_W     = 8;
    typedef logic [BLK_SEL_W-1:0] blk_sel_t;
    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;
endpackage

// File: rtl/mux_sel_rr_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority encoder, first set req bit scanning from ptr upward with wrap
//   req   - request vector, bit 0 = block_a
//   ptr   - highest-priority channel, 0..NUM_CH-1
//   idx   - chosen channel (0 when nothing found)
//   found - at least one request set
module rr_pick
    import mux_blk_pkg::*;
#(
    parameter int NUM_CH = NUM_BLK,
    parameter int SEL_W  = BLK_SEL_W
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  idx,
    output logic              found
);
    logic [SEL_W-1:0] scan;
    always_comb begin
        idx   = '0;
        found = 1'b0;
        scan  = ptr;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && req[scan]) begin
                idx   = scan;
                found = 1'b1;
            end
            // explicit wrap at NUM_CH-1 so the scan never leaves 0..NUM_CH-1
            scan = (scan == SEL_W'(NUM_CH - 1)) ? '0 : scan + SEL_W'(1);
        end
    end
endmodule

// File: rtl/mux_sel_rr_arbiter.sv
// mux_sel_rr_arbiter: round-robin arbiter producing the registered select for the 10-way block mux
//   clk, rst     - clock, synchronous active-high reset
//   req          - one request per block, bit 0 = block_a
//   grant_ready  - consumer accepts the current selection
//   grant_valid  - sel holds a valid grant
//   sel          - selected channel, always 0..NUM_CH-1
//   grant_onehot - one-hot of sel while grant_valid, else 0
module mux_sel_rr_arbiter
    import mux_blk_pkg::*;
#(
    parameter int NUM_CH = NUM_BLK,
    parameter int SEL_W  = BLK_SEL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              grant_ready,
    output logic              grant_valid,
    output logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] grant_onehot
);
    arb_state_t        state, state_next;
    logic [SEL_W-1:0]  ptr, ptr_next, sel_next, pick_idx;
    logic [NUM_CH-1:0] onehot_next;
    logic              pick_found, hs;

    assign grant_valid = (state == ARB_GRANT);
    assign hs          = grant_valid && grant_ready;
    // on handshake the served channel drops to lowest priority
    assign ptr_next    = hs ? ((sel == SEL_W'(NUM_CH - 1)) ? '0 : sel + SEL_W'(1)) : ptr;

    rr_pick #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_next),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        state_next = state;
        sel_next   = sel;
        if (state == ARB_IDLE || hs) begin
            state_next = pick_found ? ARB_GRANT : ARB_IDLE;
            sel_next   = pick_found ? pick_idx : sel;
        end
        onehot_next = (state_next == ARB_GRANT) ? NUM_CH'(1) << sel_next : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ARB_IDLE;
            ptr          <= '0;
            sel          <= '0;
            grant_onehot <= '0;
        end else begin
            state        <= state_next;
            ptr          <= ptr_next;
            sel          <= sel_next;
            grant_onehot <= onehot_next;
        end
    end
endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// tb_mux_sel_rr_arbiter: directed self-checking bench for mux_sel_rr_arbiter
module tb_mux_sel_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] req;
    logic       grant_ready;
    logic       grant_valid;
    logic [3:0] sel;
    logic [9:0] grant_onehot;
    int         n_vec = 0;
    int         n_err = 0;

    mux_sel_rr_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .grant_ready  (grant_ready),
        .grant_valid  (grant_valid),
        .sel          (sel),
        .grant_onehot (grant_onehot)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [3:0] s);
        chk({tag, ".valid"}, 32'(grant_valid), 32'(v));
        chk({tag, ".sel"}, 32'(sel), 32'(s));
        chk({tag, ".onehot"}, 32'(grant_onehot), v ? 32'(10'd1 << s) : 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        req = 10'h3FF;
        grant_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("reset", 1'b0, 4'd0);
        end
        chk("reset.ptr", 32'(dut.ptr), 32'd0);
        rst = 1'b0;
        tick();
        chk_out("first_grant", 1'b1, 4'd0);

        grant_ready = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            chk_out($sformatf("rot%0d", k), 1'b1, 4'(k % 10));
        end

        req = 10'h020;
        tick();
        chk_out("stall_load", 1'b1, 4'd5);
        grant_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) req = 10'h000;
            tick();
            chk_out($sformatf("stall%0d", c), 1'b1, 4'd5);
        end
        grant_ready = 1'b1;
        tick();
        chk_out("drain_idle", 1'b0, 4'd5);
        tick();
        chk_out("stay_idle", 1'b0, 4'd5);

        req = 10'h200;
        grant_ready = 1'b0;
        tick();
        chk_out("grant9", 1'b1, 4'd9);
        req = 10'h201;
        grant_ready = 1'b1;
        tick();
        chk_out("wrap0", 1'b1, 4'd0);
        tick();
        chk_out("skip9", 1'b1, 4'd9);
        tick();
        chk_out("wrap0b", 1'b1, 4'd0);

        req = 10'h008;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk_out($sformatf("sole%0d", c), 1'b1, 4'd3);
        end

        req = 10'h080;
        tick();
        chk_out("grant7", 1'b1, 4'd7);
        grant_ready = 1'b0;
        tick();
        chk_out("hold7", 1'b1, 4'd7);
        rst = 1'b1;
        req = 10'h3FF;
        grant_ready = 1'b1;
        tick();
        chk_out("rst_mid", 1'b0, 4'd0);
        chk("rst_mid.ptr", 32'(dut.ptr), 32'd0);
        rst = 1'b0;
        tick();
        chk_out("post_rst", 1'b1, 4'd0);
        tick();
        chk_out("post_rst_next", 1'b1, 4'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
